// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared LSU definitions: FSM encoding, load funct3 codes, trap causes and AXI response codes.
package ysyx_24110006_lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StWr,
        StB,
        StDone
    } lsu_state_e;

    localparam logic [2:0] LoadLb  = 3'b000;
    localparam logic [2:0] LoadLh  = 3'b001;
    localparam logic [2:0] LoadLw  = 3'b010;
    localparam logic [2:0] LoadLbu = 3'b100;
    localparam logic [2:0] LoadLhu = 3'b101;

    localparam logic [3:0] LoadAccessFault  = 4'd5;
    localparam logic [3:0] StoreAccessFault = 4'd7;

    localparam logic [1:0] RespOkay = 2'b00;

endpackage

// File: rtl/ysyx_24110006_lsu_if.sv
// AXI4-lite style read/write channels between the LSU (master) and the memory side (slave).
interface ysyx_24110006_lsu_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational load extraction/extension and store lane shifting.
module ysyx_24110006_lsu_align
    import ysyx_24110006_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  read_t,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] load_data,
    output logic [31:0] wdata_sh,
    output logic [3:0]  wstrb
);

    logic [31:0] sh;

    assign sh       = rdata >> {offset, 3'b000};
    assign wdata_sh = wdata << {offset, 3'b000};
    assign wstrb    = wmask << offset;

    always_comb begin
        load_data = '0;
        case (read_t)
            LoadLb:  load_data = {{24{sh[7]}}, sh[7:0]};
            LoadLh:  load_data = {{16{sh[15]}}, sh[15:0]};
            LoadLw:  load_data = sh;
            LoadLbu: load_data = {24'b0, sh[7:0]};
            LoadLhu: load_data = {16'b0, sh[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Memory-access stage: latches one instruction per handshake, runs at most one bus access,
// and presents a writeback record to the WBU.
module ysyx_24110006_lsu
    import ysyx_24110006_lsu_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_result,
    input  logic        i_result_t,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [3:0]  i_mem_wmask,
    input  logic [2:0]  i_mem_read_t,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [4:0]  i_reg_rd,
    input  logic        i_reg_wen,
    input  logic [31:0] i_pc,
    input  logic [11:0] i_csr,
    input  logic [1:0]  i_csr_t,
    input  logic        i_exception,
    input  logic [3:0]  i_mcause,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_reg_rd,
    output logic        o_reg_wen,
    output logic [31:0] o_pc,
    output logic [11:0] o_csr,
    output logic [1:0]  o_csr_t,
    output logic        o_exception,
    output logic [3:0]  o_mcause,
    ysyx_24110006_lsu_if.master bus
);

    lsu_state_e  state_q, state_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        acc;
    logic [31:0] result_q, addr_q, wdata_q, rdata_q, pc_q;
    logic        result_t_q, reg_wen_q, exception_q, csr_t_dummy;
    logic [3:0]  wmask_q, mcause_q;
    logic [2:0]  read_t_q;
    logic [4:0]  reg_rd_q;
    logic [11:0] csr_q;
    logic [1:0]  csr_t_q;
    logic [31:0] load_data;

    assign csr_t_dummy = 1'b0;
    assign acc = i_valid && o_ready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (acc) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (i_exception)    state_d = StDone;
                    else if (i_mem_ren) state_d = StAr;
                    else if (i_mem_wen) state_d = StWr;
                    else                state_d = StDone;
                end else if (state_q == StDone && i_ready) begin
                    state_d = StIdle;
                end
            end
            StAr: if (bus.arready) state_d = StR;
            StR:  if (bus.rvalid) state_d = StDone;
            StWr: begin
                // AW and W complete independently; B waits for both.
                if (bus.awvalid && bus.awready) aw_done_d = 1'b1;
                if (bus.wvalid && bus.wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)      state_d   = StB;
            end
            StB:  if (bus.bvalid) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (acc) begin
            result_q   <= i_result;
            result_t_q <= i_result_t;
            addr_q     <= i_mem_addr;
            wdata_q    <= i_mem_wdata;
            wmask_q    <= i_mem_wmask;
            read_t_q   <= i_mem_read_t;
            reg_rd_q   <= i_reg_rd;
            pc_q       <= i_pc;
            csr_q      <= i_csr;
            csr_t_q    <= i_csr_t;
        end
        if (state_q == StR && bus.rvalid) rdata_q <= bus.rdata;
    end

    // Bus errors override the forwarded trap fields and suppress the register write.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            exception_q <= 1'b0;
            reg_wen_q   <= 1'b0;
            mcause_q    <= '0;
        end else if (acc) begin
            exception_q <= i_exception;
            reg_wen_q   <= i_reg_wen;
            mcause_q    <= i_mcause;
        end else if (state_q == StR && bus.rvalid && bus.rresp != RespOkay) begin
            exception_q <= 1'b1;
            reg_wen_q   <= 1'b0;
            mcause_q    <= LoadAccessFault;
        end else if (state_q == StB && bus.bvalid && bus.bresp != RespOkay) begin
            exception_q <= 1'b1;
            reg_wen_q   <= 1'b0;
            mcause_q    <= StoreAccessFault;
        end
    end

    ysyx_24110006_lsu_align u_align (
        .rdata     (rdata_q),
        .offset    (addr_q[1:0]),
        .read_t    (read_t_q),
        .wdata     (wdata_q),
        .wmask     (wmask_q),
        .load_data (load_data),
        .wdata_sh  (bus.wdata),
        .wstrb     (bus.wstrb)
    );

    assign bus.araddr  = addr_q;
    assign bus.awaddr  = addr_q;
    assign bus.arvalid = (state_q == StAr);
    assign bus.rready  = (state_q == StR);
    assign bus.awvalid = (state_q == StWr) && !aw_done_q;
    assign bus.wvalid  = (state_q == StWr) && !w_done_q;
    assign bus.bready  = (state_q == StB);

    assign o_ready     = (state_q == StIdle) || (state_q == StDone && i_ready);
    assign o_valid     = (state_q == StDone);
    assign o_result    = result_t_q ? load_data : result_q;
    assign o_reg_rd    = reg_rd_q;
    assign o_reg_wen   = reg_wen_q;
    assign o_pc        = pc_q;
    assign o_csr       = csr_q;
    assign o_csr_t     = csr_t_q | {1'b0, csr_t_dummy};
    assign o_exception = exception_q;
    assign o_mcause    = mcause_q;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Scoreboard bench for ysyx_24110006_lsu with a latency-programmable AXI-lite slave model.
module tb_ysyx_24110006_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_valid, o_ready, i_ready, o_valid;
    logic [31:0] i_result, i_mem_addr, i_mem_wdata, i_pc;
    logic        i_result_t, i_mem_ren, i_mem_wen, i_reg_wen, i_exception;
    logic [3:0]  i_mem_wmask, i_mcause;
    logic [2:0]  i_mem_read_t;
    logic [4:0]  i_reg_rd;
    logic [11:0] i_csr;
    logic [1:0]  i_csr_t;
    logic [31:0] o_result, o_pc;
    logic [4:0]  o_reg_rd;
    logic        o_reg_wen, o_exception;
    logic [11:0] o_csr;
    logic [1:0]  o_csr_t;
    logic [3:0]  o_mcause;

    ysyx_24110006_lsu_if bus ();

    ysyx_24110006_lsu dut (
        .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_result(i_result), .i_result_t(i_result_t), .i_mem_ren(i_mem_ren),
        .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask), .i_mem_read_t(i_mem_read_t),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_reg_rd(i_reg_rd),
        .i_reg_wen(i_reg_wen), .i_pc(i_pc), .i_csr(i_csr), .i_csr_t(i_csr_t),
        .i_exception(i_exception), .i_mcause(i_mcause), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen), .o_pc(o_pc),
        .o_csr(o_csr), .o_csr_t(o_csr_t), .o_exception(o_exception), .o_mcause(o_mcause),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] result;
        logic        chk_result;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [31:0] pc;
        logic [11:0] csr;
        logic [1:0]  csr_t;
        logic        exception;
        logic [3:0]  mcause;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          retire_cnt = 0;
    int          done_rise_cyc = -1;
    logic [31:0] pc_n = 32'h8000_0000;

    // Slave model configuration and logs.
    int          ar_lat = 0, aw_lat = 0, w_lat = 0;
    logic [31:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;
    logic        force_rvalid = 1'b0;
    logic [31:0] araddr_log, awaddr_log, wdata_log;
    logic [3:0]  wstrb_log;
    int          ar_total = 0, aw_hs_cyc = -1, w_hs_cyc = -1, b_hs_cyc = -1;
    int          bready_first_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin : slave
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got, b_pend;
        int   ar_wait, aw_wait, w_wait;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
        forever begin
            @(negedge clk);
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;
            if (bus.arvalid) ar_total++;
            if (ar_hs) araddr_log = bus.araddr;
            if (aw_hs) begin awaddr_log = bus.awaddr; aw_hs_cyc = cyc; end
            if (w_hs) begin wdata_log = bus.wdata; wstrb_log = bus.wstrb; w_hs_cyc = cyc; end
            if (bus.bready && bready_first_cyc < 0) bready_first_cyc = cyc;
            if (b_hs) b_hs_cyc = cyc;
            @(posedge clk);
            #1;
            if (i_reset) begin
                rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0;
                bus.arready = 0; bus.awready = 0; bus.wready = 0;
            end else begin
                if (r_hs) rd_pend = 0;
                if (ar_hs) rd_pend = 1;
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (b_hs) b_pend = 0;
                if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
                if (bus.arvalid) begin bus.arready = (ar_wait >= ar_lat); ar_wait++; end
                else begin bus.arready = 0; ar_wait = 0; end
                if (bus.awvalid) begin bus.awready = (aw_wait >= aw_lat); aw_wait++; end
                else begin bus.awready = 0; aw_wait = 0; end
                if (bus.wvalid) begin bus.wready = (w_wait >= w_lat); w_wait++; end
                else begin bus.wready = 0; w_wait = 0; end
            end
            bus.rvalid = rd_pend || force_rvalid;
            bus.rdata  = rdata_cfg;
            bus.rresp  = rd_pend ? rresp_cfg : 2'b00;
            bus.bvalid = b_pend;
            bus.bresp  = bresp_cfg;
        end
    end

    initial begin : monitor
        exp_t x;
        logic prev_valid;
        prev_valid = 0;
        forever begin
            @(negedge clk);
            if (!i_reset && o_valid && !prev_valid) done_rise_cyc = cyc;
            prev_valid = o_valid && !i_reset;
            if (!i_reset && o_valid && i_ready) begin
                retire_cnt++;
                if (sb_q.size() == 0) begin
                    check_eq("retire_unexpected", 32'd1, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    if (x.chk_result) check_eq("wb_result", o_result, x.result);
                    check_eq("wb_rd", {27'b0, o_reg_rd}, {27'b0, x.rd});
                    check_eq("wb_reg_wen", {31'b0, o_reg_wen}, {31'b0, x.reg_wen});
                    check_eq("wb_pc", o_pc, x.pc);
                    check_eq("wb_csr", {20'b0, o_csr}, {20'b0, x.csr});
                    check_eq("wb_csr_t", {30'b0, o_csr_t}, {30'b0, x.csr_t});
                    check_eq("wb_exception", {31'b0, o_exception}, {31'b0, x.exception});
                    check_eq("wb_mcause", {28'b0, o_mcause}, {28'b0, x.mcause});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] res, input logic res_t, input logic ren,
                         input logic wen, input logic [3:0] wmask, input logic [2:0] rt,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rwen, input logic exc, input logic [3:0] mc);
        i_result = res; i_result_t = res_t; i_mem_ren = ren; i_mem_wen = wen;
        i_mem_wmask = wmask; i_mem_read_t = rt; i_mem_addr = addr; i_mem_wdata = wd;
        i_reg_rd = rd; i_reg_wen = rwen; i_pc = pc_n; i_csr = pc_n[13:2]; i_csr_t = pc_n[3:2];
        i_exception = exc; i_mcause = mc;
        e.result = res; e.chk_result = 1; e.rd = rd; e.reg_wen = rwen; e.pc = pc_n;
        e.csr = pc_n[13:2]; e.csr_t = pc_n[3:2]; e.exception = exc; e.mcause = mc;
        pc_n = pc_n + 32'd4;
    endtask

    // Holds i_valid until accepted; returns 1 ns after the accepting edge.
    task automatic issue();
        bit ok;
        ok = 0;
        i_valid = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_ready) begin ok = 1; break; end
        end
        if (ok) sb_q.push_back(e);
        else check_eq("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            check_eq("retire_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic do_load(input logic [2:0] rt, input logic [31:0] addr, input logic [31:0] rd_v,
                           input logic [1:0] rresp, input logic [31:0] exp_res, input bit lat_chk);
        rdata_cfg = rd_v; rresp_cfg = rresp;
        drive(32'h0, 1, 1, 0, 4'h0, rt, addr, 32'h0, 5'd7, 1, 0, 4'd0);
        e.result = exp_res;
        if (rresp != 2'b00) begin
            e.exception = 1; e.mcause = 4'd5; e.reg_wen = 0; e.chk_result = 0;
        end
        issue();
        i_valid = 0;
        if (lat_chk) begin
            check_eq("ld_ar_rise", {31'b0, bus.arvalid}, 32'd1);
            @(posedge clk); #1;
            check_eq("ld_not_early", {31'b0, o_valid}, 32'd0);
            @(posedge clk); #1;
            check_eq("ld_latency", {31'b0, o_valid}, 32'd1);
        end
        wait_done();
        check_eq("ld_araddr", araddr_log, addr);
    endtask

    task automatic do_store(input logic [3:0] wmask, input logic [31:0] addr, input logic [31:0] wd,
                            input int awl, input int wl, input logic [1:0] bresp,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        aw_lat = awl; w_lat = wl; bresp_cfg = bresp; bready_first_cyc = -1;
        drive(32'h5A5A_0001, 0, 0, 1, wmask, 3'b000, addr, wd, 5'd3, 1, 0, 4'd0);
        if (bresp != 2'b00) begin e.exception = 1; e.mcause = 4'd7; e.reg_wen = 0; end
        issue();
        i_valid = 0;
        wait_done();
        check_eq("st_awaddr", awaddr_log, addr);
        check_eq("st_wdata", wdata_log, exp_wd);
        check_eq("st_wstrb", {28'b0, wstrb_log}, {28'b0, exp_strb});
        check_eq("st_b_after_aw", {31'b0, bready_first_cyc > aw_hs_cyc}, 32'd1);
        check_eq("st_b_after_w", {31'b0, bready_first_cyc > w_hs_cyc}, 32'd1);
        check_eq("st_done_lat", done_rise_cyc, b_hs_cyc + 1);
        aw_lat = 0; w_lat = 0; bresp_cfg = 2'b00;
    endtask

    initial begin : main
        int r0, ar0;
        i_reset = 1; i_valid = 0; i_ready = 1;
        drive(32'h0, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd0, 0, 0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_o_valid", {31'b0, o_valid}, 32'd0);
        check_eq("rst_o_ready", {31'b0, o_ready}, 32'd1);
        check_eq("rst_valids", {27'b0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                bus.bready}, 32'd0);
        check_eq("rst_exception", {31'b0, o_exception}, 32'd0);
        check_eq("rst_reg_wen", {31'b0, o_reg_wen}, 32'd0);
        i_reset = 0;
        @(posedge clk); #1;

        // Pass-through ALU op and back-to-back throughput.
        drive(32'h1234, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd5, 1, 0, 4'd0);
        issue();
        i_valid = 0;
        check_eq("alu_latency", {31'b0, o_valid}, 32'd1);
        check_eq("alu_no_bus", {30'b0, bus.arvalid, bus.awvalid}, 32'd0);
        wait_done();
        r0 = retire_cnt;
        drive(32'h0000_1111, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd1, 1, 0, 4'd0); issue();
        drive(32'h0000_2222, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd2, 1, 0, 4'd0); issue();
        drive(32'h0000_3333, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd3, 0, 0, 4'd0); issue();
        i_valid = 0;
        @(posedge clk); #1;
        check_eq("b2b_retires", retire_cnt - r0, 32'd3);
        wait_done();

        // Loads.
        do_load(3'b000, 32'h8000_0003, 32'h80FF_0000, 2'b00, 32'hFFFF_FF80, 1);
        do_load(3'b100, 32'h8000_0003, 32'h80FF_0000, 2'b00, 32'h0000_0080, 0);
        do_load(3'b001, 32'h8000_0002, 32'h80FF_0000, 2'b00, 32'hFFFF_80FF, 0);
        do_load(3'b101, 32'h8000_0002, 32'h80FF_0000, 2'b00, 32'h0000_80FF, 0);
        do_load(3'b010, 32'h8000_0010, 32'h1234_5678, 2'b00, 32'h1234_5678, 0);
        do_load(3'b000, 32'h8000_0001, 32'h0000_7F00, 2'b00, 32'h0000_007F, 0);
        do_load(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, 0);
        do_load(3'b010, 32'h8000_0020, 32'h0BAD_0BAD, 2'b10, 32'h0, 0);

        // Stores with varied AW/W ready ordering.
        do_store(4'b0001, 32'h8000_0102, 32'h0000_00AB, 3, 0, 2'b00, 4'b0100, 32'h00AB_0000);
        do_store(4'b0011, 32'h8000_0206, 32'h1234_BEEF, 0, 2, 2'b00, 4'b1100, 32'hBEEF_0000);
        do_store(4'b1111, 32'h8000_0300, 32'hCAFE_F00D, 0, 0, 2'b00, 4'b1111, 32'hCAFE_F00D);
        do_store(4'b0001, 32'h8000_0401, 32'h0000_0055, 1, 1, 2'b11, 4'b0010, 32'h0000_5500);

        // Upstream exception bypasses the bus.
        ar0 = ar_total;
        drive(32'h0000_CAFE, 0, 1, 0, 4'h0, 3'b010, 32'h8000_0000, 32'h0, 5'd9, 1, 1, 4'd2);
        issue();
        i_valid = 0;
        wait_done();
        check_eq("exc_no_ar", ar_total - ar0, 32'd0);

        // Downstream backpressure.
        i_ready = 0;
        drive(32'h0000_0077, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd4, 1, 0, 4'd0);
        issue();
        i_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check_eq("bp_valid", {31'b0, o_valid}, 32'd1);
            check_eq("bp_ready", {31'b0, o_ready}, 32'd0);
            check_eq("bp_result", o_result, 32'h0000_0077);
            @(posedge clk); #1;
        end
        drive(32'h0000_0088, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd6, 1, 0, 4'd0);
        i_ready = 1;
        i_valid = 1;
        @(negedge clk);
        check_eq("bp_accept_same_cycle", {31'b0, o_ready}, 32'd1);
        if (o_ready) sb_q.push_back(e);
        @(posedge clk); #1;
        i_valid = 0;
        wait_done();

        // Reset while a read address is outstanding.
        ar_lat = 20;
        rdata_cfg = 32'h1111_2222;
        drive(32'h0, 1, 1, 0, 4'h0, 3'b010, 32'h8000_0040, 32'h0, 5'd8, 1, 0, 4'd0);
        issue();
        i_valid = 0;
        @(posedge clk); #1;
        check_eq("rst_ar_pending", {31'b0, bus.arvalid}, 32'd1);
        i_reset = 1;
        @(posedge clk); #1;
        i_reset = 0;
        sb_q.delete();
        check_eq("rstmid_valids", {26'b0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                   bus.bready, o_valid}, 32'd0);
        check_eq("rstmid_o_ready", {31'b0, o_ready}, 32'd1);
        ar_lat = 0;
        force_rvalid = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("stray_r_ignored", {30'b0, o_valid, o_ready}, 32'd1);
        end
        force_rvalid = 0;
        @(posedge clk); #1;
        drive(32'h0000_ABCD, 0, 0, 0, 4'h0, 3'b0, 32'h0, 32'h0, 5'd10, 1, 0, 4'd0);
        issue();
        i_valid = 0;
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
